// File: rtl/solver_job_driver_pkg.sv
// solver_job_driver_pkg
// Shared definitions for the solver job driver and the solver it feeds:
//   - default limb/iteration widths, kept identical to the solver's own defaults
//   - FSM state encoding for the job driver
package solver_job_driver_pkg;

  localparam int LIMB_INDEX_BITS_DEF = 6;
  localparam int LIMB_SIZE_BITS_DEF  = 8;
  localparam int ITER_BITS_DEF       = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONFIG = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;

endpackage

// File: rtl/solver_job_driver.sv
// solver_job_driver
// Master-side controller for one solver instance. Accepts a job header and a
// limb stream over valid/ready, programs the solver's config/limb write port,
// pulses start, waits for out_ready (optionally under a watchdog) and returns
// the iteration count over a result valid/ready handshake. One job in flight.
//
// Ports:
//   clock, reset                     clock (rising edge), async active-low reset
//   job_valid/job_ready              header handshake (job_num_limbs, job_iter_lim)
//   limb_valid/limb_ready            limb stream handshake (limb_re, limb_im), index 0 first
//   wr_real_en, wr_imag_en, wr_index, real_data, imag_data     solver limb writes
//   wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data  solver config writes
//   start                            one-cycle solver start pulse
//   out_ready, iterations            solver done flag and result
//   res_valid/res_ready              result handshake (res_iterations, res_timeout)
//   busy                             high whenever a job is in progress
module solver_job_driver
  import solver_job_driver_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = LIMB_INDEX_BITS_DEF,
  parameter int LIMB_SIZE_BITS  = LIMB_SIZE_BITS_DEF,
  parameter int ITER_BITS       = ITER_BITS_DEF,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [LIMB_INDEX_BITS-1:0] job_num_limbs,
  input  logic [ITER_BITS-1:0]       job_iter_lim,
  input  logic                       limb_valid,
  output logic                       limb_ready,
  input  logic [LIMB_SIZE_BITS-1:0]  limb_re,
  input  logic [LIMB_SIZE_BITS-1:0]  limb_im,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_index,
  output logic [LIMB_SIZE_BITS-1:0]  real_data,
  output logic [LIMB_SIZE_BITS-1:0]  imag_data,
  output logic                       wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic                       wr_iter_lim_en,
  output logic [ITER_BITS-1:0]       iter_lim_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [ITER_BITS-1:0]       iterations,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ITER_BITS-1:0]       res_iterations,
  output logic                       res_timeout,
  output logic                       busy
);

  localparam int WD_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_BITS-1:0] WD_LAST =
    WD_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [2:0]                 state;
  logic [LIMB_INDEX_BITS-1:0] limb_cnt;
  logic [WD_BITS-1:0]         wd_cnt;

  // Handshake readies come straight from the state so they never lag it.
  // job_ready is additionally gated by reset so it stays low while held in reset.
  assign job_ready  = (state == S_IDLE) && reset;
  assign limb_ready = (state == S_LOAD);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      limb_cnt        <= '0;
      wd_cnt          <= '0;
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_index        <= '0;
      real_data       <= '0;
      imag_data       <= '0;
      wr_num_limbs_en <= 1'b0;
      num_limbs_data  <= '0;
      wr_iter_lim_en  <= 1'b0;
      iter_lim_data   <= '0;
      start           <= 1'b0;
      res_valid       <= 1'b0;
      res_iterations  <= '0;
      res_timeout     <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle so every write is a single-cycle
      // pulse; non-blocking assignments let the case below override them.
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_num_limbs_en <= 1'b0;
      wr_iter_lim_en  <= 1'b0;
      start           <= 1'b0;

      case (state)
        S_IDLE: begin
          if (job_valid) begin
            // The config data registers double as the latched job header.
            num_limbs_data  <= job_num_limbs;
            iter_lim_data   <= job_iter_lim;
            wr_num_limbs_en <= 1'b1;
            wr_iter_lim_en  <= 1'b1;
            limb_cnt        <= '0;
            state           <= S_CONFIG;
          end
        end

        S_CONFIG: begin
          state <= (num_limbs_data == '0) ? S_START : S_LOAD;
        end

        S_LOAD: begin
          if (limb_valid) begin
            wr_real_en <= 1'b1;
            wr_imag_en <= 1'b1;
            wr_index   <= limb_cnt;
            real_data  <= limb_re;
            imag_data  <= limb_im;
            limb_cnt   <= limb_cnt + 1'b1;
            // Compare against count-1 so a full-range count never needs the
            // counter to wrap.
            if (limb_cnt == num_limbs_data - 1'b1) state <= S_START;
          end
        end

        S_START: begin
          // The last limb strobe is visible in this cycle; start follows it.
          start <= 1'b1;
          state <= S_SETTLE;
        end

        S_SETTLE: begin
          // start is visible now; out_ready may still be the previous job's
          // flag until the solver has seen start, so it is not looked at.
          wd_cnt <= '0;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          if (out_ready) begin
            res_iterations <= iterations;
            res_timeout    <= 1'b0;
            res_valid      <= 1'b1;
            state          <= S_RESULT;
          end else if (TIMEOUT_CYCLES != 0 && wd_cnt == WD_LAST) begin
            res_iterations <= '0;
            res_timeout    <= 1'b1;
            res_valid      <= 1'b1;
            state          <= S_RESULT;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_solver_job_driver.sv
// tb_solver_job_driver
// Self-checking bench for solver_job_driver. A behavioural solver stub answers
// each job with min(sum over limbs of (index+1)*(re+im), iter_lim) a few cycles
// after start, or never when stub_hang is set. Expected limb writes and results
// are queued when a job is issued; a monitor pops and compares them whenever
// the DUT presents a write strobe or a result transfer.
module tb_solver_job_driver;
  import solver_job_driver_pkg::*;

  localparam int LIB      = 6;
  localparam int LSB      = 8;
  localparam int IB       = 16;
  localparam int TO       = 8;
  localparam int STUB_LAT = 3;

  typedef int limbs_t[4];
  typedef struct { int idx; int re; int im; } wr_t;
  typedef struct { int iter; int to; } res_t;

  logic           clock, reset;
  logic           job_valid, job_ready;
  logic [LIB-1:0] job_num_limbs;
  logic [IB-1:0]  job_iter_lim;
  logic           limb_valid, limb_ready;
  logic [LSB-1:0] limb_re, limb_im;
  logic           wr_real_en, wr_imag_en;
  logic [LIB-1:0] wr_index;
  logic [LSB-1:0] real_data, imag_data;
  logic           wr_num_limbs_en;
  logic [LIB-1:0] num_limbs_data;
  logic           wr_iter_lim_en;
  logic [IB-1:0]  iter_lim_data;
  logic           start;
  logic           out_ready;
  logic [IB-1:0]  iterations;
  logic           res_valid, res_ready;
  logic [IB-1:0]  res_iterations;
  logic           res_timeout;
  logic           busy;

  solver_job_driver #(
    .LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LSB), .ITER_BITS(IB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_num_limbs(job_num_limbs), .job_iter_lim(job_iter_lim),
    .limb_valid(limb_valid), .limb_ready(limb_ready),
    .limb_re(limb_re), .limb_im(limb_im),
    .wr_real_en(wr_real_en), .wr_imag_en(wr_imag_en), .wr_index(wr_index),
    .real_data(real_data), .imag_data(imag_data),
    .wr_num_limbs_en(wr_num_limbs_en), .num_limbs_data(num_limbs_data),
    .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data),
    .start(start), .out_ready(out_ready), .iterations(iterations),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_iterations(res_iterations), .res_timeout(res_timeout),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int start_cyc = 0;
  int start_cnt = 0;
  int wr_cnt = 0;
  int exp_cfg_n = 0;
  int exp_cfg_lim = 0;
  wr_t  wr_q[$];
  res_t res_q[$];
  logic stub_hang;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Solver stub
  int            stub_acc, stub_cnt;
  logic [IB-1:0] stub_lim;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_ready <= 1'b0;
      iterations <= '0;
      stub_acc <= 0;
      stub_cnt <= 0;
      stub_lim <= '0;
    end else begin
      if (wr_iter_lim_en) begin
        stub_lim <= iter_lim_data;
        stub_acc <= 0;
      end else if (wr_real_en && wr_imag_en) begin
        stub_acc <= stub_acc + (int'(wr_index) + 1) * (int'(real_data) + int'(imag_data));
      end
      if (start) begin
        out_ready <= 1'b0;
        stub_cnt  <= STUB_LAT;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1 && !stub_hang) begin
          out_ready  <= 1'b1;
          iterations <= (stub_acc > int'(stub_lim)) ? stub_lim : IB'(stub_acc);
        end
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (reset) begin
      if (wr_num_limbs_en || wr_iter_lim_en) begin
        check("cfg_strobes", {30'd0, wr_num_limbs_en, wr_iter_lim_en}, 32'd3);
        check("cfg_num_limbs", num_limbs_data, exp_cfg_n);
        check("cfg_iter_lim", iter_lim_data, exp_cfg_lim);
      end
      if (wr_real_en || wr_imag_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (wr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got index %0d expected no write", wr_index);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_both_strobes", {30'd0, wr_real_en, wr_imag_en}, 32'd3);
          check("wr_index", wr_index, w.idx);
          check("real_data", real_data, w.re);
          check("imag_data", imag_data, w.im);
        end
      end
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
        check("start_while_res_valid", res_valid, 0);
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got %0d expected no result", res_iterations);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("res_iterations", res_iterations, r.iter);
          check("res_timeout", res_timeout, r.to);
        end
      end
    end
  end

  task automatic send_job(input int n, input int lim, input limbs_t re, input limbs_t im,
                          input int gap);
    bit ok;
    exp_cfg_n = n;
    exp_cfg_lim = lim;
    for (int i = 0; i < n; i++) wr_q.push_back('{i, re[i], im[i]});
    @(posedge clock); #1;
    job_valid = 1'b1;
    job_num_limbs = LIB'(n);
    job_iter_lim = IB'(lim);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (job_ready) begin ok = 1'b1; break; end
    end
    check("job_accept_in_time", ok, 1);
    @(posedge clock); #1;
    job_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      limb_valid = 1'b1;
      limb_re = LSB'(re[i]);
      limb_im = LSB'(im[i]);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clock);
        if (limb_ready) begin ok = 1'b1; break; end
      end
      check("limb_accept_in_time", ok, 1);
      @(posedge clock); #1;
      limb_valid = 1'b0;
      if (gap > 0 && i < n - 1) begin
        repeat (gap) @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic take_result(input int hold, input int exp_iter);
    bit ok;
    res_ready = (hold == 0);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (res_valid) begin ok = 1'b1; break; end
    end
    check("res_valid_in_time", ok, 1);
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        check("hold_res_valid", res_valid, 1);
        check("hold_res_iterations", res_iterations, exp_iter);
        check("hold_job_ready", job_ready, 0);
        @(negedge clock);
      end
      @(posedge clock); #1;
      res_ready = 1'b1;
    end
    @(posedge clock); #1;
    @(negedge clock);
    check("res_valid_dropped", res_valid, 0);
    check("job_ready_after_result", job_ready, 1);
  endtask

  task automatic do_job(input int n, input int lim, input limbs_t re, input limbs_t im,
                        input int gap, input int hold, input int exp_iter, input int exp_to);
    int s0;
    s0 = start_cnt;
    res_q.push_back('{exp_iter, exp_to});
    send_job(n, lim, re, im, gap);
    take_result(hold, exp_iter);
    check("single_start_pulse", start_cnt - s0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int w0;
    bit seen;
    reset = 1'b0;
    job_valid = 1'b0; job_num_limbs = '0; job_iter_lim = '0;
    limb_valid = 1'b0; limb_re = '0; limb_im = '0;
    res_ready = 1'b0;
    stub_hang = 1'b0;
    #1;
    check("rst_job_ready", job_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_start", start, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_job_ready", job_ready, 1);
    check("post_rst_limb_ready", limb_ready, 0);

    // Basic job: 1*(1+1) + 2*(0+0) = 2, under the limit of 10.
    do_job(2, 10, '{1, 0, 0, 0}, '{1, 0, 0, 0}, 0, 0, 2, 0);
    check("basic_start_after_last_write", start_cyc - last_wr_cyc, 1);

    // Repeatability, back-to-back with res_ready held high.
    for (int r = 0; r < 4; r++)
      do_job(2, 10, '{1, 0, 0, 0}, '{1, 0, 0, 0}, 0, 0, 2, 0);

    // 1*8 + 2*8 + 3*6 = 42, then the same limbs clipped by a limit of 20.
    do_job(3, 100, '{5, 7, 2, 0}, '{3, 1, 4, 0}, 0, 0, 42, 0);
    do_job(3, 20, '{5, 7, 2, 0}, '{3, 1, 4, 0}, 0, 0, 20, 0);

    // Limb stalls (valid 1,0,0,1): 1*11 + 2*22 = 55.
    do_job(2, 200, '{10, 20, 0, 0}, '{1, 2, 0, 0}, 2, 0, 55, 0);
    check("stall_start_after_last_write", start_cyc - last_wr_cyc, 1);

    // Result backpressure for 5 cycles: 1*(9+6) = 15.
    do_job(1, 300, '{9, 0, 0, 0}, '{6, 0, 0, 0}, 0, 5, 15, 0);

    // No limbs: straight to start, no limb writes, result 0.
    w0 = wr_cnt;
    do_job(0, 9, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 0, 0);
    check("zero_limbs_no_writes", wr_cnt - w0, 0);

    // Watchdog: solver never answers.
    stub_hang = 1'b1;
    do_job(1, 5, '{3, 0, 0, 0}, '{4, 0, 0, 0}, 0, 0, 0, 1);

    // Reset while waiting on a hung solver: job is dropped silently.
    send_job(1, 5, '{3, 0, 0, 0}, '{4, 0, 0, 0}, 0);
    repeat (4) @(negedge clock);
    check("wait_busy_before_reset", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_job_ready", job_ready, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_start", start, 0);
    check("midrst_wr_en", {30'd0, wr_real_en, wr_imag_en}, 0);
    check("midrst_cfg_en", {30'd0, wr_num_limbs_en, wr_iter_lim_en}, 0);
    check("midrst_res_timeout", res_timeout, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    stub_hang = 1'b0;
    res_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (res_valid) seen = 1'b1;
    end
    check("no_result_after_reset", seen, 0);
    check("job_ready_after_reset", job_ready, 1);

    // Normal operation resumes after the mid-job reset.
    do_job(2, 50, '{2, 3, 0, 0}, '{2, 1, 0, 0}, 0, 0, 12, 0);

    check("res_queue_drained", res_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/solver_job_driver.md
Name: solver_job_driver

Overview:
- Master-side controller for `solver`: programs the solver's write/config port, pulses `start`, waits for `out_ready`, and returns the iteration count.
- Accepts a job header and a limb stream on valid/ready handshakes, so host logic (UART/bus bridge) feeds jobs without cycle-exact sequencing.
- Sits between the host interface and one `solver` instance; one job in flight at a time.

Parameters:
- LIMB_INDEX_BITS, 6, width of limb index and limb count (same as solver).
- LIMB_SIZE_BITS, 8, width of one limb (same as solver).
- ITER_BITS, 16, width of iteration limit and result.
- TIMEOUT_CYCLES, 0, WAIT-state watchdog in cycles; 0 disables the watchdog.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- job_valid / job_ready  in / out  1 / 1  job header handshake.
- job_num_limbs  in  LIMB_INDEX_BITS  limbs per coordinate.
- job_iter_lim  in  ITER_BITS  iteration limit.
- limb_valid / limb_ready  in / out  1 / 1  limb stream handshake, index 0 first.
- limb_re / limb_im  in  LIMB_SIZE_BITS each  real/imag limb values.
- wr_real_en, wr_imag_en  out  1  solver limb write strobes.
- wr_index  out  LIMB_INDEX_BITS  solver limb write index.
- real_data, imag_data  out  LIMB_SIZE_BITS  solver limb data.
- wr_num_limbs_en  out  1  solver limb-count write strobe; num_limbs_data  out  LIMB_INDEX_BITS.
- wr_iter_lim_en  out  1  solver iteration-limit write strobe; iter_lim_data  out  ITER_BITS.
- start  out  1  one-cycle solver start pulse.
- out_ready  in  1  solver done; iterations  in  ITER_BITS  solver result.
- res_valid / res_ready  out / in  1 / 1  result handshake.
- res_iterations  out  ITER_BITS  captured result.
- res_timeout  out  1  result produced by watchdog, not by the solver.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0, except job_ready=1 once reset deasserts.
  - Reset mid-job abandons the job silently; no result is produced.
- All solver-side outputs are registered; strobes are high for exactly one cycle per write.
- Handshakes: transfer occurs on the rising edge with valid&&ready. job_ready=(state==IDLE); limb_ready=(state==LOAD).
- IDLE: on header transfer, latch num_limbs/iter_lim and clear the limb counter -> CONFIG.
- CONFIG (1 cycle): wr_num_limbs_en=wr_iter_lim_en=1 with latched values.
  - Next state is LOAD, or START if num_limbs==0.
- LOAD:
  - Each accepted limb produces, in the following cycle, wr_real_en=wr_imag_en=1, wr_index=counter, and data; counter then increments.
  - Throughput is 1 limb/cycle; gaps in limb_valid insert idle cycles with strobes low.
  - After limb num_limbs-1 is accepted, limb_ready drops the next cycle -> START.
- START (1 cycle): start=1. This cycle follows the last write strobe (or CONFIG if there are no limbs) -> SETTLE.
- SETTLE (1 cycle): out_ready is ignored here, because a stale flag from the previous job may still be high -> WAIT.
- WAIT: clear and run the watchdog counter.
  - On out_ready=1, capture iterations into res_iterations, res_timeout=0 -> RESULT.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES first: res_iterations=0, res_timeout=1 -> RESULT.
  - If out_ready and timeout occur in the same cycle, out_ready wins.
- RESULT: res_valid=1, held with stable data until res_ready.
  - On transfer: res_valid=0 -> IDLE; job_ready=1 the following cycle.
- Minimum job latency with no stalls: header accept -> result valid = N + 4 cycles plus the solver compute time.
- The limb counter is LIMB_INDEX_BITS wide; num_limbs up to 2^LIMB_INDEX_BITS-1 is supported and does not wrap.
- Limb stream traffic outside LOAD is not accepted (limb_ready=0); it is not an error.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, CONFIG, LOAD, START, SETTLE, WAIT, RESULT);
  - LIMB_INDEX_BITS/LIMB_SIZE_BITS/ITER_BITS defaults shared with `solver`.
- Single module: FSM plus counters. No sub-module is needed; the watchdog counter is inline.

Test Plan:
- Basic job against a real solver (widths 6/8, radius 4): header num_limbs=2, iter_lim=10; limbs re={1,0}, im={1,0}.
  - Expect strobes at index 0 then 1, and a single start pulse.
  - Expect res_valid with res_iterations equal to the solver's count and res_timeout=0.
- Repeatability: run the same job 4 times back-to-back with res_ready=1. All four res_iterations must be identical, and no start may fire before the previous result is transferred.
- Limb-stream stalls: limb_valid toggles 1,0,0,1. Exactly 2 write strobes occur with wr_index 0,1, and start comes 1 cycle after the second strobe.
- Result backpressure: hold res_ready=0 for 5 cycles. res_valid and res_iterations stay stable, job_ready stays 0, and a single transfer occurs when res_ready=1.
- Watchdog: TIMEOUT_CYCLES=8 with a stub solver that never raises out_ready. Expect res_valid with res_timeout=1 and res_iterations=0.
- Edge cases:
  - Reset pulsed low during WAIT returns all outputs to 0 and job_ready to 1, with no res_valid.
  - num_limbs=0 gives CONFIG -> START with no limb strobes.
